// File: rtl/facto_master.sv
// facto_master: single-job bus master for the FactoCore system.
// Programs the core, releases the bus while it computes, then on interrupt (or timeout) reads the
// 128-bit result, stores both halves to RAM and clears the core.
module facto_master #(
    parameter logic [15:0] CORE_BASE = 16'h7000,
    parameter logic [15:0] RAM_BASE  = 16'h0000,
    parameter logic [19:0] TIMEOUT   = 20'd1000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [63:0] cmd_operand,
    input  logic [7:0]  cmd_slot,
    output logic        done,
    output logic        error,
    output logic        m_req,
    input  logic        m_grant,
    output logic        m_wr,
    output logic [15:0] m_addr,
    output logic [63:0] m_dout,
    input  logic [63:0] m_din,
    input  logic        interrupt
);

    localparam logic [15:0] OffStart   = 16'h0000;
    localparam logic [15:0] OffClear   = 16'h0008;
    localparam logic [15:0] OffIntrEn  = 16'h0018;
    localparam logic [15:0] OffOperand = 16'h0020;
    localparam logic [15:0] OffResH    = 16'h0028;
    localparam logic [15:0] OffResL    = 16'h0030;

    typedef enum logic [3:0] {
        StIdle, StReq1, StWOpnd, StWIen, StWStart, StWaitIrq, StReq2,
        StRH, StRL, StWRh, StWRl, StWClr, StWIen0, StDone
    } state_e;

    state_e      r_state;
    logic [63:0] r_operand;
    logic [7:0]  r_slot;
    logic [63:0] r_result_h;
    logic [63:0] r_result_l;
    logic [19:0] r_timer;
    logic        r_abort;
    logic        r_rd_pend;   // read issued last cycle; m_din carries its data now
    logic        r_rd_lo;     // pending read targets result_l
    logic        r_cmd_ready;
    logic        r_done;
    logic        r_error;
    logic        r_m_req;
    logic        r_m_wr;
    logic [15:0] r_m_addr;
    logic [63:0] r_m_dout;

    state_e      w_state_nxt;
    logic        w_issue;
    logic        w_abort_nxt;
    logic [63:0] w_res_h;
    logic [63:0] w_res_l;
    logic [15:0] w_ram_addr;
    logic        w_req_nxt;
    logic        w_wr_nxt;
    logic [15:0] w_addr_nxt;
    logic [63:0] w_dout_nxt;

    assign cmd_ready = r_cmd_ready;
    assign done      = r_done;
    assign error     = r_error;
    assign m_req     = r_m_req;
    assign m_wr      = r_m_wr;
    assign m_addr    = r_m_addr;
    assign m_dout    = r_m_dout;

    // Next state, plus the bus outputs the next state will present (registered below).
    always_comb begin
        w_issue     = r_m_req & m_grant;
        // Forward read data arriving this cycle so the RAM write can be loaded without a bubble.
        w_res_h     = (r_rd_pend && !r_rd_lo) ? m_din : r_result_h;
        w_res_l     = (r_rd_pend && r_rd_lo) ? m_din : r_result_l;
        w_ram_addr  = RAM_BASE + {4'h0, r_slot, 4'h0};
        w_state_nxt = r_state;
        w_abort_nxt = r_abort;

        unique case (r_state)
            StIdle:    if (cmd_valid) begin
                           w_state_nxt = StReq1;
                           w_abort_nxt = 1'b0;
                       end
            StReq1:    if (w_issue) w_state_nxt = StWOpnd;
            StWOpnd:   if (w_issue) w_state_nxt = StWIen;
            StWIen:    if (w_issue) w_state_nxt = StWStart;
            StWStart:  if (w_issue) w_state_nxt = StWaitIrq;
            StWaitIrq: if (interrupt) begin
                           w_state_nxt = StReq2;
                       end else if (r_timer == TIMEOUT - 20'd1) begin
                           w_state_nxt = StReq2;
                           w_abort_nxt = 1'b1;
                       end
            StReq2:    if (w_issue) w_state_nxt = r_abort ? StWClr : StRH;
            StRH:      if (w_issue) w_state_nxt = StRL;
            StRL:      if (w_issue) w_state_nxt = StWRh;
            StWRh:     if (w_issue) w_state_nxt = StWRl;
            StWRl:     if (w_issue) w_state_nxt = StWClr;
            StWClr:    if (w_issue) w_state_nxt = StWIen0;
            StWIen0:   if (w_issue) w_state_nxt = StDone;
            StDone:    w_state_nxt = StIdle;
            default:   w_state_nxt = StIdle;
        endcase

        w_req_nxt  = 1'b1;
        w_wr_nxt   = 1'b1;
        w_addr_nxt = '0;
        w_dout_nxt = '0;
        unique case (w_state_nxt)
            StWOpnd:  begin w_addr_nxt = CORE_BASE + OffOperand; w_dout_nxt = r_operand; end
            StWIen:   begin w_addr_nxt = CORE_BASE + OffIntrEn;  w_dout_nxt = 64'd1;     end
            StWStart: begin w_addr_nxt = CORE_BASE + OffStart;   w_dout_nxt = 64'd1;     end
            StRH:     begin w_addr_nxt = CORE_BASE + OffResH;    w_wr_nxt   = 1'b0;      end
            StRL:     begin w_addr_nxt = CORE_BASE + OffResL;    w_wr_nxt   = 1'b0;      end
            StWRh:    begin w_addr_nxt = w_ram_addr;             w_dout_nxt = w_res_h;   end
            StWRl:    begin w_addr_nxt = w_ram_addr + 16'h0008;  w_dout_nxt = w_res_l;   end
            StWClr:   begin w_addr_nxt = CORE_BASE + OffClear;   w_dout_nxt = 64'd1;     end
            StWIen0:  begin w_addr_nxt = CORE_BASE + OffIntrEn;  w_dout_nxt = 64'd0;     end
            // Bus-acquire cycles: request held with a neutral address.
            StReq1, StReq2: w_wr_nxt = 1'b0;
            default:  begin w_req_nxt = 1'b0; w_wr_nxt = 1'b0; end
        endcase
    end

    // FSM state, job registers and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StIdle;
            r_operand   <= '0;
            r_slot      <= '0;
            r_result_h  <= '0;
            r_result_l  <= '0;
            r_timer     <= '0;
            r_abort     <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_rd_lo     <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_m_req     <= 1'b0;
            r_m_wr      <= 1'b0;
            r_m_addr    <= '0;
            r_m_dout    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_abort     <= w_abort_nxt;
            r_cmd_ready <= (w_state_nxt == StIdle);
            r_done      <= (w_state_nxt == StDone);
            r_error     <= (w_state_nxt == StDone) && w_abort_nxt;
            r_m_req     <= w_req_nxt;
            r_m_wr      <= w_wr_nxt;
            r_m_addr    <= w_addr_nxt;
            r_m_dout    <= w_dout_nxt;

            if (r_state == StIdle && cmd_valid) begin
                r_operand <= cmd_operand;
                r_slot    <= cmd_slot;
            end

            // Timer restarts from zero each time WAIT_IRQ is entered.
            if (r_state == StWaitIrq) r_timer <= r_timer + 20'd1;
            else                      r_timer <= '0;

            r_rd_pend <= w_issue && (r_state == StRH || r_state == StRL);
            r_rd_lo   <= (r_state == StRL);
            if (r_rd_pend) begin
                if (r_rd_lo) r_result_l <= m_din;
                else         r_result_h <= m_din;
            end
        end
    end

endmodule

// File: tb/tb_facto_master.sv
// Bench for facto_master: a bus slave model (FactoCore registers + interrupt) drives the DUTs;
// issued accesses are logged and compared with traces built from the job description.
module tb_facto_master;

    localparam logic [15:0] CB = 16'h7000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [63:0] cmd_operand = '0;
    logic [7:0]  cmd_slot = '0;
    logic        m_grant = 1'b1;
    logic [63:0] m_din = '0;
    logic        interrupt = 1'b0;

    logic        cmd_ready0, done0, error0, m_req0, m_wr0;
    logic [15:0] m_addr0;
    logic [63:0] m_dout0;
    logic        cmd_ready1, done1, error1, m_req1, m_wr1;
    logic [15:0] m_addr1;
    logic [63:0] m_dout1;

    always #5 clk = ~clk;

    facto_master #(.CORE_BASE(16'h7000), .RAM_BASE(16'h0000), .TIMEOUT(20'd50)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready0),
        .cmd_operand(cmd_operand), .cmd_slot(cmd_slot), .done(done0), .error(error0),
        .m_req(m_req0), .m_grant(m_grant), .m_wr(m_wr0), .m_addr(m_addr0), .m_dout(m_dout0),
        .m_din(m_din), .interrupt(interrupt)
    );

    facto_master #(.CORE_BASE(16'h7000), .RAM_BASE(16'hF800), .TIMEOUT(20'd50)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready1),
        .cmd_operand(cmd_operand), .cmd_slot(cmd_slot), .done(done1), .error(error1),
        .m_req(m_req1), .m_grant(m_grant), .m_wr(m_wr1), .m_addr(m_addr1), .m_dout(m_dout1),
        .m_din(m_din), .interrupt(interrupt)
    );

    int cmp_cnt = 0;
    int fail_cnt = 0;
    int cyc = 0;
    logic [63:0]  rd_next = '0;
    bit           g_rand = 1'b0;
    int           irq_dly_cfg = -1;
    int           irq_cnt = 0;
    bit           irq_arm = 1'b0;
    logic [63:0]  core_op = '0;
    logic [127:0] core_res = '0;
    // Trace entry: {wr, addr[15:0], data[63:0]}
    logic [80:0]  trace0[$];
    logic [80:0]  trace1[$];
    logic [80:0]  exp_q[$];
    int done_cnt = 0, err_cnt = 0, viol = 0, st_cyc = 0;
    int done_cyc[$];
    int acc_cyc[$];
    int rise_cyc[$];
    logic prev_req = 1'b0;

    function automatic logic [127:0] fact(input logic [63:0] n);
        logic [127:0] r = 128'd1;
        for (int i = 2; i <= int'(n); i++) r = r * 128'(i);
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Drive grant and read data just after each rising edge.
    initial forever begin
        @(posedge clk);
        #1;
        m_din   = rd_next;
        m_grant = g_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Slave model and bus monitor, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        rd_next = {$urandom, $urandom};
        if (m_req0 && m_grant) begin
            // A granted read of address 0 is the master's bus-acquire cycle, not a data access.
            if (m_wr0 || m_addr0 != 16'h0) trace0.push_back({m_wr0, m_addr0, m_dout0});
            if (!m_wr0 && m_addr0 == CB + 16'h28) rd_next = core_res[127:64];
            if (!m_wr0 && m_addr0 == CB + 16'h30) rd_next = core_res[63:0];
            if (m_wr0 && m_addr0 == CB + 16'h20) core_op = m_dout0;
            if (m_wr0 && m_addr0 == CB && m_dout0 == 64'd1) begin
                core_res = fact(core_op);
                st_cyc   = cyc;
                irq_arm  = (irq_dly_cfg >= 0);
                irq_cnt  = irq_dly_cfg;
            end
            if (m_wr0 && m_addr0 == CB + 16'h08 && m_dout0[0]) begin
                interrupt = 1'b0;
                irq_arm   = 1'b0;
            end
        end
        if (m_req1 && m_grant && (m_wr1 || m_addr1 != 16'h0))
            trace1.push_back({m_wr1, m_addr1, m_dout1});
        if (irq_arm) begin
            if (irq_cnt == 0) begin
                interrupt = 1'b1;
                irq_arm   = 1'b0;
            end else begin
                irq_cnt--;
            end
        end
        if (!m_req0 && (m_addr0 != 16'h0 || m_wr0)) viol++;
        if (!m_wr0 && m_dout0 != 64'h0) viol++;
        if (m_req0 && cmd_ready0) viol++;
        if (error0 && !done0) viol++;
        if (done0) begin
            done_cnt++;
            done_cyc.push_back(cyc);
        end
        if (error0) err_cnt++;
        if (cmd_valid && cmd_ready0) acc_cyc.push_back(cyc);
        if (m_req0 && !prev_req) rise_cyc.push_back(cyc);
        prev_req = m_req0;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", cmp_cnt);
        $fatal(1, "watchdog");
    end

    task automatic clear_logs();
        trace0.delete();
        trace1.delete();
        done_cyc.delete();
        acc_cyc.delete();
        rise_cyc.delete();
        done_cnt = 0;
        err_cnt  = 0;
        viol     = 0;
    endtask

    task automatic build_exp(input logic [63:0] op, input logic [7:0] slot,
                             input logic [15:0] base, input bit abort);
        logic [127:0] r = fact(op);
        logic [15:0]  a = base + 16'(slot) * 16'd16;
        exp_q.delete();
        exp_q.push_back({1'b1, CB + 16'h20, op});
        exp_q.push_back({1'b1, CB + 16'h18, 64'd1});
        exp_q.push_back({1'b1, CB, 64'd1});
        if (!abort) begin
            exp_q.push_back({1'b0, CB + 16'h28, 64'd0});
            exp_q.push_back({1'b0, CB + 16'h30, 64'd0});
            exp_q.push_back({1'b1, a, r[127:64]});
            exp_q.push_back({1'b1, a + 16'd8, r[63:0]});
        end
        exp_q.push_back({1'b1, CB + 16'h08, 64'd1});
        exp_q.push_back({1'b1, CB + 16'h18, 64'd0});
    endtask

    // Submit one job and wait (bounded) for its done pulse.
    task automatic run_job(input logic [63:0] op, input logic [7:0] slot, input int dly,
                           output bit to);
        int n = 0;
        clear_logs();
        irq_dly_cfg = dly;
        to = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid   = 1'b1;
        cmd_operand = op;
        cmd_slot    = slot;
        do begin
            @(negedge clk);
            n++;
        end while (!cmd_ready0 && n < 100);
        if (!cmd_ready0) to = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done0 && n < 3000);
        if (!done0) to = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        int n = 0;
        bit to;
        repeat (3) @(negedge clk);
        cmp_cnt++; if (cmd_ready0 !== 1'b1) begin fail_cnt++;
            $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready0); end
        cmp_cnt++; if ({m_req0, m_wr0, done0, error0} !== 4'b0) begin fail_cnt++;
            $display("FAIL reset_ctrl_outs: got %b want 0000", {m_req0, m_wr0, done0, error0}); end
        cmp_cnt++; if ({m_addr0, m_dout0} !== 80'h0) begin fail_cnt++;
            $display("FAIL reset_bus_outs: got %h want 0", {m_addr0, m_dout0}); end
        @(posedge clk); #1 reset_n = 1'b1;
        // Start a job and pull reset while the operand write is on the bus.
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_operand = 64'd7; cmd_slot = 8'd1;
        do begin
            @(negedge clk);
            n++;
        end while (!(m_wr0 && m_addr0 == CB + 16'h20) && n < 50);
        cmp_cnt++; if (!(m_wr0 && m_addr0 == CB + 16'h20)) begin fail_cnt++;
            $display("FAIL reach_w_opnd: got addr %h wr %b want 7020 1", m_addr0, m_wr0); end
        cmd_valid = 1'b0;
        #1 reset_n = 1'b0;
        #1;
        cmp_cnt++; if ({m_req0, m_wr0, done0} !== 3'b000) begin fail_cnt++;
            $display("FAIL midjob_reset_bus: got %b want 000", {m_req0, m_wr0, done0}); end
        cmp_cnt++; if (cmd_ready0 !== 1'b1) begin fail_cnt++;
            $display("FAIL midjob_reset_ready: got %b want 1", cmd_ready0); end
        @(posedge clk); #1 reset_n = 1'b1;
        run_job(64'd9, 8'd2, 5, to);
        build_exp(64'd9, 8'd2, 16'h0000, 1'b0);
        cmp_cnt++; if (to || trace0.size() != exp_q.size()) begin fail_cnt++;
            $display("FAIL after_reset_len: got %0d timeout %b want %0d", trace0.size(), to,
                     exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < trace0.size(); i++) begin
            cmp_cnt++; if (trace0[i] !== exp_q[i]) begin fail_cnt++;
                $display("FAIL after_reset_acc%0d: got %h want %h", i, trace0[i], exp_q[i]); end
        end
    endtask

    task automatic test_basic();
        bit to;
        g_rand = 1'b0;
        run_job(64'd5, 8'd3, 20, to);
        build_exp(64'd5, 8'd3, 16'h0000, 1'b0);
        cmp_cnt++; if (to || trace0.size() != exp_q.size()) begin fail_cnt++;
            $display("FAIL basic_len: got %0d timeout %b want %0d", trace0.size(), to,
                     exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < trace0.size(); i++) begin
            cmp_cnt++; if (trace0[i] !== exp_q[i]) begin fail_cnt++;
                $display("FAIL basic_acc%0d: got %h want %h", i, trace0[i], exp_q[i]); end
        end
        if (trace0.size() > 6) begin
            cmp_cnt++; if (trace0[6] !== {1'b1, 16'h0038, 64'd120}) begin fail_cnt++;
                $display("FAIL basic_ram_lo: got %h want 1_0038_120", trace0[6]); end
        end
        cmp_cnt++; if (done_cnt !== 1 || err_cnt !== 0 || viol !== 0) begin fail_cnt++;
            $display("FAIL basic_flags: got done %0d err %0d viol %0d want 1 0 0", done_cnt,
                     err_cnt, viol); end
    endtask

    task automatic test_grant_toggle();
        bit to;
        logic [63:0] op;
        logic [7:0]  slot;
        g_rand = 1'b1;
        for (int j = 0; j < 5; j++) begin
            op   = (j == 0) ? 64'd20 : 64'($urandom_range(0, 34));
            slot = 8'($urandom_range(0, 255));
            run_job(op, slot, int'($urandom_range(0, 30)), to);
            build_exp(op, slot, 16'h0000, 1'b0);
            cmp_cnt++; if (to || trace0.size() != exp_q.size()) begin fail_cnt++;
                $display("FAIL toggle_len op %0d: got %0d timeout %b want %0d", op,
                         trace0.size(), to, exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < trace0.size(); i++) begin
                cmp_cnt++; if (trace0[i] !== exp_q[i]) begin fail_cnt++;
                    $display("FAIL toggle_acc%0d op %0d: got %h want %h", i, op, trace0[i],
                             exp_q[i]); end
            end
            if (j == 0 && trace0.size() > 6) begin
                cmp_cnt++; if (trace0[6][63:0] !== 64'h21C3677C82B40000) begin fail_cnt++;
                    $display("FAIL toggle_fact20: got %h want 21c3677c82b40000",
                             trace0[6][63:0]); end
            end
            cmp_cnt++; if (done_cnt !== 1 || err_cnt !== 0 || viol !== 0) begin fail_cnt++;
                $display("FAIL toggle_flags: got done %0d err %0d viol %0d want 1 0 0",
                         done_cnt, err_cnt, viol); end
        end
        g_rand = 1'b0;
    endtask

    task automatic test_timeout();
        bit to;
        run_job(64'd4, 8'd1, -1, to);
        build_exp(64'd4, 8'd1, 16'h0000, 1'b1);
        cmp_cnt++; if (to || trace0.size() != exp_q.size()) begin fail_cnt++;
            $display("FAIL timeout_len: got %0d timeout %b want %0d", trace0.size(), to,
                     exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < trace0.size(); i++) begin
            cmp_cnt++; if (trace0[i] !== exp_q[i]) begin fail_cnt++;
                $display("FAIL timeout_acc%0d: got %h want %h", i, trace0[i], exp_q[i]); end
        end
        cmp_cnt++; if (done_cnt !== 1 || err_cnt !== 1 || viol !== 0) begin fail_cnt++;
            $display("FAIL timeout_flags: got done %0d err %0d viol %0d want 1 1 0", done_cnt,
                     err_cnt, viol); end
        // Start write issues in cycle t; 50 cycles of waiting; request rises in t+51.
        cmp_cnt++; if (rise_cyc.size() < 2 || rise_cyc[1] - st_cyc != 51) begin fail_cnt++;
            $display("FAIL timeout_wait: got %0d want 51",
                     (rise_cyc.size() < 2) ? -1 : rise_cyc[1] - st_cyc); end
    endtask

    task automatic test_wrap();
        bit to;
        run_job(64'd6, 8'hFF, 3, to);
        build_exp(64'd6, 8'hFF, 16'hF800, 1'b0);
        cmp_cnt++; if (to || trace1.size() != exp_q.size()) begin fail_cnt++;
            $display("FAIL wrap_len: got %0d timeout %b want %0d", trace1.size(), to,
                     exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < trace1.size(); i++) begin
            cmp_cnt++; if (trace1[i] !== exp_q[i]) begin fail_cnt++;
                $display("FAIL wrap_acc%0d: got %h want %h", i, trace1[i], exp_q[i]); end
        end
        if (trace1.size() > 6) begin
            cmp_cnt++; if ({trace1[5][79:64], trace1[6][79:64]} !== 32'h07F0_07F8) begin
                fail_cnt++;
                $display("FAIL wrap_addrs: got %h %h want 07f0 07f8", trace1[5][79:64],
                         trace1[6][79:64]); end
        end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int seen = 0;
        clear_logs();
        irq_dly_cfg = 2;
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_operand = 64'd3; cmd_slot = 8'd0;
        while (seen < 2 && n < 3000) begin
            @(negedge clk);
            n++;
            if (done0) seen++;
        end
        @(posedge clk); #1 cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        cmp_cnt++; if (seen != 2 || acc_cyc.size() != 2 || done_cyc.size() != 2) begin
            fail_cnt++;
            $display("FAIL b2b_counts: got done %0d acc %0d want 2 2", seen, acc_cyc.size());
        end
        if (acc_cyc.size() == 2 && done_cyc.size() == 2) begin
            cmp_cnt++; if (acc_cyc[1] != done_cyc[0] + 1) begin fail_cnt++;
                $display("FAIL b2b_accept_cycle: got %0d want %0d", acc_cyc[1],
                         done_cyc[0] + 1); end
        end
        cmp_cnt++; if (trace0.size() != 18 || viol !== 0) begin fail_cnt++;
            $display("FAIL b2b_trace: got %0d accesses viol %0d want 18 0", trace0.size(),
                     viol); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_grant_toggle();
        test_timeout();
        test_wrap();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
